// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: FSM state encoding and requester IDs shared by the arbiter files
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RDATA  = 2'd2
    } state_t;

    localparam logic ID0 = 1'b0;
    localparam logic ID1 = 1'b1;

    // Requester 0 wins the first tie after reset, so the last winner starts as 1
    localparam logic RR_LAST_RST = ID1;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker producing a one-hot grant
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    // A lone requester wins; on a tie the one that did not win last time wins
    always_comb begin
        gnt[0] = req[0] & (~req[1] | last);
        gnt[1] = req[1] & (~req[0] | ~last);
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between two requesters
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [DEPTH-1:0] addr0,
    input  logic [DEPTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] rdata,
    output logic             ram_enable,
    output logic             ram_wr_en,
    output logic [DEPTH-1:0] ram_address,
    output logic [WIDTH-1:0] ram_data_in,
    input  logic [WIDTH-1:0] ram_data_out
);

    state_t           state_q, state_d;
    logic             who_q, who_d;
    logic             we_q, we_d;
    logic [DEPTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rr_last_q, rr_last_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             done0_q, done0_d, done1_q, done1_d;
    logic [1:0]       pick;

    rr_arb2 u_rr (
        .req  ({req1, req0}),
        .last (rr_last_q),
        .gnt  (pick)
    );

    // RAM strobes come straight from the state register; address/data from the command latch
    always_comb begin
        ram_enable  = (state_q == S_ACCESS);
        ram_wr_en   = (state_q == S_ACCESS) & we_q;
        ram_address = addr_q;
        ram_data_in = wdata_q;
        gnt0        = gnt0_q;
        gnt1        = gnt1_q;
        done0       = done0_q;
        done1       = done1_q;
        rdata       = rdata_q;
    end

    // Next state: arbitrate and latch in IDLE, strobe in ACCESS, capture read data in RDATA
    always_comb begin
        state_d   = state_q;
        who_d     = who_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rr_last_d = rr_last_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|pick) begin
                    who_d     = pick[1] ? ID1 : ID0;
                    we_d      = pick[1] ? we1 : we0;
                    addr_d    = pick[1] ? addr1 : addr0;
                    wdata_d   = pick[1] ? wdata1 : wdata0;
                    gnt0_d    = pick[0];
                    gnt1_d    = pick[1];
                    rr_last_d = pick[1] ? ID1 : ID0;
                    state_d   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    done0_d = (who_q == ID0);
                    done1_d = (who_q == ID1);
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                rdata_d = ram_data_out;
                done0_d = (who_q == ID0);
                done1_d = (who_q == ID1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output pulse registers; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            who_q     <= ID0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rr_last_q <= RR_LAST_RST;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            who_q     <= who_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rr_last_q <= rr_last_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed plus random checks of ram_arbiter against a memory/round-robin model
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [3:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, done0, done1, ram_enable, ram_wr_en;
    logic [7:0] rdata, ram_data_in;
    logic [3:0] ram_address;
    logic [7:0] ram_dout = '0;

    logic [7:0] mem [16];
    logic [7:0] ref_mem [16];
    bit         last = 1'b1;
    logic [7:0] exp_rdata = '0, exp_din = '0;
    logic [3:0] exp_addr = '0;
    int         tests = 0, fails = 0;

    ram_arbiter #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
        .ram_enable(ram_enable), .ram_wr_en(ram_wr_en), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_enable) begin
            if (ram_wr_en) mem[ram_address] <= ram_data_in;
            else ram_dout <= mem[ram_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_pulses"}, {gnt0, gnt1, done0, done1, ram_enable, ram_wr_en}, 0);
        chk({tag, "_rdata"}, rdata, exp_rdata);
        chk({tag, "_addr"}, ram_address, exp_addr);
        chk({tag, "_din"}, ram_data_in, exp_din);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            chk_quiet("idle");
        end
    endtask

    task automatic op(input bit r0, input bit r1, input bit w0, input bit w1,
                      input logic [3:0] a0, input logic [3:0] a1,
                      input logic [7:0] d0, input logic [7:0] d1, output bit win);
        bit         ww;
        logic [3:0] wa;
        logic [7:0] wd;
        win = (r0 && r1) ? !last : r1;
        ww  = win ? w1 : w0;
        wa  = win ? a1 : a0;
        wd  = win ? d1 : d0;
        req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        @(posedge clk); #1;
        chk("gnt", {gnt0, gnt1, done0, done1}, win ? 4'b0100 : 4'b1000);
        chk("strobe", {ram_enable, ram_wr_en}, {1'b1, ww});
        chk("acc_addr", ram_address, wa);
        chk("acc_din", ram_data_in, wd);
        last = win; exp_addr = wa; exp_din = wd;
        if (win) req1 = 1'b0; else req0 = 1'b0;
        addr0 = 4'($urandom); addr1 = 4'($urandom);
        wdata0 = 8'($urandom); wdata1 = 8'($urandom);
        we0 = 1'($urandom); we1 = 1'($urandom);
        if (ww) begin
            ref_mem[wa] = wd;
            @(posedge clk); #1;
            chk("wdone", {gnt0, gnt1, done0, done1, ram_enable}, win ? 5'b00010 : 5'b00100);
            chk("wdone_rdata", rdata, exp_rdata);
        end else begin
            @(posedge clk); #1;
            chk("rwait", {gnt0, gnt1, done0, done1, ram_enable, ram_wr_en}, 0);
            chk("rwait_addr", ram_address, wa);
            @(posedge clk); #1;
            exp_rdata = ref_mem[wa];
            chk("rdone", {gnt0, gnt1, done0, done1, ram_enable}, win ? 5'b00010 : 5'b00100);
            chk("rdata", rdata, exp_rdata);
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        bit w;
        bit [3:0] order;
        for (int i = 0; i < 16; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst_n = 1'b1;
        idle(10);

        op(1, 0, 1, 0, 4'd3, 4'd0, 8'hA5, 8'h00, w);
        chk("first_win", w, 0);
        op(0, 1, 0, 0, 4'd0, 4'd3, 8'h00, 8'h00, w);
        chk("read_back", rdata, 8'hA5);

        for (int i = 0; i < 4; i++) begin
            op(1, 1, 0, 0, 4'(i), 4'(i + 8), 8'h00, 8'h00, w);
            order[i] = w;
        end
        chk("alternate", order, 4'b1010);

        op(1, 0, 1, 0, 4'd15, 4'd0, 8'hFF, 8'h00, w);
        op(0, 1, 0, 1, 4'd0, 4'd0, 8'h00, 8'h01, w);
        op(1, 0, 0, 0, 4'd15, 4'd0, 8'h00, 8'h00, w);
        chk("addr15", rdata, 8'hFF);
        op(0, 1, 0, 0, 4'd0, 4'd0, 8'h00, 8'h00, w);
        chk("addr0", rdata, 8'h01);
        idle(2);

        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
        @(posedge clk); #1;
        chk("pre_rst_gnt", {gnt0, ram_enable}, 2'b11);
        req0 = 1'b0;
        rst_n = 1'b0;
        #1;
        last = 1'b1; exp_rdata = '0; exp_addr = '0; exp_din = '0;
        chk_quiet("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        op(1, 1, 0, 0, 4'd15, 4'd0, 8'h00, 8'h00, w);
        chk("rst_first", w, 0);

        for (int i = 0; i < 60; i++) begin
            int v;
            v = $urandom_range(1, 3);
            op(v[0], v[1], 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
               8'($urandom), 8'($urandom), w);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
